fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Drain stage placed directly downstream of the 16x8 synchronous FIFO. It pops one byte at a time through the FIFO's rd/dout/empty interface and serialises each byte onto a single UART line: 8N1, LSB first, fixed clock-per-bit divisor. It handles the FIFO's one-cycle registered read latency. It also handles the FIFO's write-over-read priority: a pop is never issued in a cycle where the FIFO accepts a write.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
DATA_W, 8, byte width; must match the FIFO data width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
fifo_empty  in  1  FIFO empty flag.
fifo_dout  in  DATA_W  FIFO registered read data; valid the cycle after a successful rd.
fifo_wr_busy  in  1  high when the FIFO accepts a write this cycle (wr && !full); a rd in that cycle would be ignored.
fifo_rd  out  1  FIFO pop request; combinational.
tx  out  1  serial line; idles high.
busy  out  1  high from the FETCH state through the end of STOP.
byte_done  out  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-low, on rst_n.
- Reset values: tx=1, fifo_rd=0, busy=0, byte_done=0, state=IDLE, baud counter=0, bit index=0.
- fifo_rd = (state==IDLE) && !fifo_empty && !fifo_wr_busy && rst_n. No other state asserts it.
- FSM states and transitions:
  - IDLE: moves to FETCH on any cycle where fifo_rd=1; otherwise stays.
  - FETCH: lasts exactly one cycle. Captures fifo_dout into the shift register, then moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift register LSB drives tx; one bit per CLKS_PER_BIT cycles; 8 bits.
  - PARITY: present only with the optional feature.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then back to IDLE.
- Timing:
  - If rd is issued in cycle N, tx falls at the start of cycle N+2.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Minimum gap between frames is 2 idle-high cycles (the IDLE cycle plus the FETCH cycle) when the FIFO stays non-empty.
- Baud counter: counts 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary. The bit index increments only at the wrap.
- Boundary conditions:
  - fifo_empty rising during a frame has no effect; the current frame completes.
  - fifo_wr_busy=1 while in IDLE suppresses the pop for that cycle; it is retried the next cycle.
  - Reset mid-frame: the frame is aborted and tx=1 from the next edge. The byte already popped is discarded and not re-read.
  - fifo_dout is sampled only in FETCH; its value in all other states is ignored.

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT cycles.
- Undefined:
  - The PARITY state and its logic are absent.
  - Frame length is 10*CLKS_PER_BIT cycles.

Decomposition:
- Package uart_tx_pkg:
  - state enum tx_state_t {IDLE, FETCH, START, DATA, PARITY, STOP};
  - localparam DATA_BITS=8;
  - localparam STOP_BITS=1.
- Sub-module baud_tick_gen(clk, rst_n, en, tick):
  - parameterised by CLKS_PER_BIT;
  - counter clears when en=0;
  - tick is high in the last cycle of each bit.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- Reset check: hold rst_n=0 for 3 cycles with fifo_empty=0 -> fifo_rd=0, tx=1, busy=0 throughout; the first fifo_rd occurs in the first cycle after rst_n=1.
- Single byte: FIFO holds 0xA5 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. byte_done pulses in cycle 40 after fifo_rd. Exactly one fifo_rd pulse.
- Back-to-back: FIFO holds 0x00 and 0xFF -> two frames with exactly 2 high cycles between them; second frame data bits all 1. Two fifo_rd pulses, 42 cycles apart.
- Write collision: fifo_empty=0 and fifo_wr_busy=1 for 3 cycles while IDLE -> fifo_rd=0 during those cycles; fifo_rd=1 in the cycle fifo_wr_busy drops.
- Mid-frame reset: assert rst_n=0 during DATA bit 3 of 0x3C -> tx=1 and busy=0 the next cycle. After release, the next FIFO byte is transmitted, not 0x3C.
- Parity (FIFO_UART_TX_PARITY_EN defined): byte 0x07 -> parity bit 1 after the 8 data bits; frame is 44 cycles; byte_done pulses in cycle 44 after fifo_rd.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and frame constants for fifo_uart_tx (rev 1.0).
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// baud_tick_gen: bit-period counter; tick marks the last clock of each UART bit (rev 1.0).
`default_nettype none

module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Held at zero while disabled so every bit period starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read FIFO and sends them as 8N1 UART frames (rev 1.0).
// Optional even parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
`default_nettype none

module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_wr_busy,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              baud_en;
  logic              tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // A pop is withheld whenever the FIFO is taking a write, since the FIFO would drop it.
  assign fifo_rd   = (state_q == IDLE) && !fifo_empty && !fifo_wr_busy && rst_n;
  assign baud_en   = (state_q != IDLE) && (state_q != FETCH);
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign byte_done = (state_q == STOP) && tick;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (baud_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_rd) state_d = FETCH;
      end
      FETCH: begin
        shift_d  = fifo_dout;
        idx_d    = '0;
        tx_d     = 1'b0;
        state_d  = START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_dout;
`endif
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire
